// File: rtl/dff_ram_pkg.sv
// dff_ram_pkg: shared types and constants for the dual-port flop RAM.
//   state_t : controller states (INIT clear sweep, RUN normal operation)
//   LANE_W  : byte-lane width for masked writes
package dff_ram_pkg;
  localparam int LANE_W = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/dff_ram_bank.sv
// dff_ram_bank: one bank of flop storage, WORDS words of WIDTH bits.
// Byte-masked synchronous write, asynchronous (combinational) read.
// Contents have no reset; the top-level INIT sweep clears them.
// Ports:
//   clk            : write clock (rising edge)
//   we/waddr/wdata : write request, word-in-bank address, data
//   wmask          : per-byte write enable, bit i -> wdata[8i+7:8i]
//   raddr/rdata    : word-in-bank read address, combinational read data
module dff_ram_bank
  import dff_ram_pkg::*;
#(
  parameter  int WIDTH = 72,
  parameter  int WORDS = 4,
  localparam int WW    = $clog2(WORDS),
  localparam int NL    = WIDTH / LANE_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NL-1:0]    wmask,
  input  logic [WW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < NL; l++) begin
        if (wmask[l]) mem[waddr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dff_ram_2p.sv
// dff_ram_2p: one-write/one-read flop RAM split into BANKS banks.
// After reset an INIT sweep zeroes one word per cycle (DEPTH cycles);
// ports are ignored until init_done. Reads have 1-cycle latency.
// Optional macro DFF_RAM_BYPASS_EN: a same-address read during a write
// returns the newly written lanes merged over the old word; without it
// the whole old word is returned.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   we, waddr, wdata, wmask    : write port with byte-lane mask
//   re, raddr                  : read request
//   rdata, rvalid              : registered read data / update strobe
//   init_done                  : clear sweep finished, ports live
module dff_ram_2p
  import dff_ram_pkg::*;
#(
  parameter  int WIDTH = 72,
  parameter  int DEPTH = 8,
  parameter  int BANKS = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int NL    = WIDTH / LANE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NL-1:0]    wmask,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             init_done
);

  localparam int WORDS = DEPTH / BANKS;
  localparam int WW    = $clog2(WORDS);
  localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1;

  state_t        state, state_nxt;
  logic [AW-1:0] init_ptr, init_ptr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state    <= state_nxt;
      init_ptr <= init_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_ptr_nxt = init_ptr;
    case (state)
      INIT: begin
        init_ptr_nxt = init_ptr + 1'b1;
        if (init_ptr == AW'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  logic run;
  assign run       = (state == RUN);
  assign init_done = run;

  // During INIT the write port is hijacked by the sweep: full-mask zero write.
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [NL-1:0]    mem_wmask;

  assign mem_we    = run ? we    : 1'b1;
  assign mem_waddr = run ? waddr : init_ptr;
  assign mem_wdata = run ? wdata : '0;
  assign mem_wmask = run ? wmask : '1;

  // Bank = upper address bits, word-in-bank = lower WW bits.
  logic [BW-1:0] wbank, rbank;
  assign wbank = BW'(mem_waddr >> WW);
  assign rbank = BW'(raddr >> WW);

  logic [BANKS-1:0][WIDTH-1:0] bank_rdata;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    dff_ram_bank #(
      .WIDTH (WIDTH),
      .WORDS (WORDS)
    ) u_bank (
      .clk   (clk),
      .we    (mem_we && (wbank == BW'(b))),
      .waddr (mem_waddr[WW-1:0]),
      .wdata (mem_wdata),
      .wmask (mem_wmask),
      .raddr (raddr[WW-1:0]),
      .rdata (bank_rdata[b])
    );
  end

  logic [WIDTH-1:0] rd_word, rd_fwd;
  assign rd_word = bank_rdata[rbank];

`ifdef DFF_RAM_BYPASS_EN
  // Forward the written lanes so a colliding read sees the post-write word.
  always_comb begin
    rd_fwd = rd_word;
    if (we && (waddr == raddr)) begin
      for (int l = 0; l < NL; l++) begin
        if (wmask[l]) rd_fwd[l*LANE_W +: LANE_W] = wdata[l*LANE_W +: LANE_W];
      end
    end
  end
`else
  // Async bank read before the edge already yields the pre-write word.
  assign rd_fwd = rd_word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= run && re;
      if (run && re) rdata <= rd_fwd;
    end
  end

endmodule

// File: tb/tb_dff_ram_2p.sv
// tb_dff_ram_2p: directed plus randomized checks of dff_ram_2p against
// an array-based reference model. Honors DFF_RAM_BYPASS_EN for collisions.
module tb_dff_ram_2p;
  localparam int W  = 72;
  localparam int D  = 8;
  localparam int NL = W / 8;
  localparam int AW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we, re;
  logic [AW-1:0] waddr, raddr;
  logic [W-1:0]  wdata;
  logic [NL-1:0] wmask;
  logic [W-1:0]  rdata;
  logic          rvalid, init_done;

  always #5 clk = ~clk;

  dff_ram_2p #(.WIDTH(W), .DEPTH(D), .BANKS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .wmask     (wmask),
    .re        (re),
    .raddr     (raddr),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .init_done (init_done)
  );

  // Reference model: word array plus count of sweep cycles still owed.
  logic [W-1:0] mdl [D];
  int           sweep_left;
  logic [W-1:0] exp_rdata;
  logic         exp_rvalid;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                                          input logic [NL-1:0] m);
    logic [W-1:0] r;
    r = old_w;
    for (int l = 0; l < NL; l++) if (m[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic model_reset();
    sweep_left = D;
    exp_rdata  = '0;
    exp_rvalid = 1'b0;
  endtask

  // Apply one clock of the spec rules to the model using current inputs.
  task automatic model_step();
    if (sweep_left > 0) begin
      mdl[D - sweep_left] = '0;
      sweep_left--;
      exp_rvalid = 1'b0;
    end else begin
      exp_rvalid = re;
      if (re) begin
        exp_rdata = mdl[raddr];
`ifdef DFF_RAM_BYPASS_EN
        if (we && waddr == raddr) exp_rdata = merge(mdl[raddr], wdata, wmask);
`endif
      end
      if (we) mdl[waddr] = merge(mdl[waddr], wdata, wmask);
    end
  endtask

  // One clock: update model, advance DUT, compare all outputs after the edge.
  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, "_rvalid"}, W'(rvalid), W'(exp_rvalid));
    chk({tag, "_rdata"}, rdata, exp_rdata);
    chk({tag, "_done"}, W'(init_done), W'(sweep_left == 0));
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [NL-1:0] m);
    we = 1'b1; waddr = a; wdata = d; wmask = m;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    re = 1'b1; raddr = a;
  endtask

  initial begin
    logic [W-1:0]  c_exp;
    logic [31:0]   r32;
    rst_n = 1'b0; we = 1'b0; re = 1'b0;
    waddr = '0; raddr = '0; wdata = '0; wmask = '0;
    for (int i = 0; i < D; i++) mdl[i] = 'x;
    model_reset();
    #2;
    chk("rst_rdata", rdata, '0);
    chk("rst_rvalid", W'(rvalid), '0);
    chk("rst_done", W'(init_done), '0);

    // Sweep with port traffic that must be dropped.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < D; i++) begin
      if (i == 2) begin wr(3, rnd_word(), '1); rd(3); end
      else idle();
      cyc("sweep");
    end
    idle();
    chk("sweep_done_after_8", W'(init_done), W'(1));

    // All words cleared; streaming back-to-back reads.
    for (int a = 0; a < D; a++) begin
      rd(a);
      cyc("clr_read");
      chk("clr_zero", rdata, '0);
    end
    idle();
    cyc("idle0");

    // Masked write.
    wr(5, {W{1'b1}}, '1); cyc("mw1");
    wr(5, '0, 9'h001);    cyc("mw2");
    idle(); rd(5);        cyc("mw_rd");
    c_exp = 72'hFF_FFFF_FFFF_FFFF_FF00;
    chk("mw_const", rdata, c_exp);
    idle();               cyc("mw_idle");
    chk("hold_rdata", rdata, c_exp);

    // Bank split.
    wr(3, 72'h1, '1); cyc("bs_w3");
    wr(4, 72'h2, '1); cyc("bs_w4");
    idle(); rd(3);    cyc("bs_r3");
    chk("bs_const3", rdata, 72'h1);
    rd(4);            cyc("bs_r4");
    chk("bs_const4", rdata, 72'h2);

    // Same-address collision.
    idle(); wr(2, 72'hAA, '1); cyc("col_pre");
    wr(2, 72'hBB, '1); rd(2);  cyc("col");
`ifdef DFF_RAM_BYPASS_EN
    chk("col_const", rdata, 72'hBB);
`else
    chk("col_const", rdata, 72'hAA);
`endif
    // Different-address simultaneous write and read.
    wr(6, 72'h1234, '1); rd(5); cyc("dual");
    idle(); rd(6);             cyc("dual_chk");
    chk("dual_const", rdata, 72'h1234);

    // Streaming reads of 0..3.
    for (int a = 0; a < 4; a++) begin
      idle(); rd(a);
      cyc("stream");
      chk("stream_vld", W'(rvalid), W'(1));
    end
    idle(); cyc("stream_end");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r32   = $urandom;
      we    = r32[0];
      re    = r32[1];
      waddr = r32[4:2];
      raddr = (r32[7:5] == 3'd0) ? r32[4:2] : r32[10:8];
      wdata = rnd_word();
      wmask = (r32[13:11] == 3'd0) ? '0 : NL'($urandom);
      cyc("rand");
    end
    idle();

    // Reset mid-read: outputs drop at once.
    rd(6); cyc("pre_rst_rd");
    #2 rst_n = 1'b0;
    #1;
    chk("mrd_rdata", rdata, '0);
    chk("mrd_rvalid", W'(rvalid), '0);
    chk("mrd_done", W'(init_done), '0);
    model_reset();
    idle();
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset at sweep cycle 3, then a full fresh sweep.
    for (int i = 0; i < 3; i++) cyc("ms_part");
    #2 rst_n = 1'b0;
    #1;
    chk("ms_rdata", rdata, '0);
    chk("ms_rvalid", W'(rvalid), '0);
    chk("ms_done", W'(init_done), '0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < D; i++) begin
      if (i < D - 1) chk("ms_not_done", W'(init_done), '0);
      cyc("ms_sweep");
    end
    chk("ms_done_8", W'(init_done), W'(1));
    for (int a = 0; a < D; a++) begin
      rd(a);
      cyc("ms_read");
      chk("ms_zero", rdata, '0);
    end
    idle();
    cyc("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dff_ram_2p.md
DFF_RAM_2P -- requirements
Module: dff_ram_2p

Interface
REQ-001 SHALL have parameter WIDTH, default 72, data word width in bits; multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 8, words stored; power of two, at least 4.
REQ-003 SHALL have parameter BANKS, default 2, bank count; power of two, at most DEPTH/2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port we, input, 1 bit: write request.
REQ-007 SHALL have port waddr, input, clog2(DEPTH) bits: write address.
REQ-008 SHALL have port wdata, input, WIDTH bits: write data.
REQ-009 SHALL have port wmask, input, WIDTH/8 bits: byte-lane write enable; bit i covers wdata[8i+7:8i].
REQ-010 SHALL have port re, input, 1 bit: read request.
REQ-011 SHALL have port raddr, input, clog2(DEPTH) bits: read address.
REQ-012 SHALL have port rdata, output, WIDTH bits: registered read data.
REQ-013 SHALL have port rvalid, output, 1 bit: rdata updated this cycle.
REQ-014 SHALL have port init_done, output, 1 bit: clear sweep finished, ports accepted.

Function
REQ-015 SHALL use an FSM with states INIT and RUN.
REQ-016 INIT: clear word init_ptr to zero each cycle, init_ptr counting 0 to DEPTH-1; after clearing word DEPTH-1, go to RUN. INIT SHALL take exactly DEPTH cycles.
REQ-017 In INIT, we and re SHALL be ignored and dropped; init_done=0 and rvalid=0.
REQ-018 In RUN, init_done=1; the FSM SHALL stay in RUN until reset.
REQ-019 Bank select SHALL be the upper clog2(BANKS) address bits; word-in-bank SHALL be the remaining lower bits.
REQ-020 A write with we=1 SHALL update only the byte lanes whose wmask bit is 1 at the clock edge; wmask=0 SHALL leave memory unchanged.
REQ-021 A read with re=1 at edge N SHALL drive rdata with the addressed word and rvalid=1 after edge N, giving 1-cycle latency.
REQ-022 With re=0, rvalid SHALL be 0 after the edge and rdata SHALL hold its previous value.
REQ-023 Back-to-back reads SHALL be supported every cycle with no bubbles.
REQ-024 When we and re are both 1 and waddr != raddr, both operations SHALL complete in the same cycle, independently.
REQ-025 Same-address read and write in the same cycle SHALL follow REQ-034/REQ-035.
REQ-026 Out-of-range addresses cannot occur, since DEPTH is a power of two.

Reset
REQ-027 rst_n low SHALL immediately set rdata=0, rvalid=0, init_done=0, state=INIT and init_ptr=0.
REQ-028 Memory contents SHALL NOT be reset asynchronously; they are cleared by the INIT sweep.
REQ-029 Reset asserted mid-sweep or mid-read SHALL abandon the operation and restart INIT from word 0 after release.
REQ-030 After rst_n rises, the first clock edge SHALL begin the sweep at word 0.

Configuration
REQ-031 The feature macro SHALL be named DFF_RAM_BYPASS_EN.
REQ-032 The macro SHALL control read-during-write forwarding.
REQ-033 The macro SHALL apply only to REQ-025 and SHALL NOT change any other behaviour.
REQ-034 With DFF_RAM_BYPASS_EN defined, a same-address read SHALL return the new data for lanes with wmask=1 and the old data for the other lanes.
REQ-035 With DFF_RAM_BYPASS_EN undefined, a same-address read SHALL return the entire old word.

Structure
REQ-036 Package dff_ram_pkg SHALL hold the state_t enum (INIT, RUN) and the LANE_W=8 constant.
REQ-037 Sub-module dff_ram_bank SHALL hold one bank: DEPTH/BANKS words, masked write, asynchronous read.
REQ-038 dff_ram_2p SHALL instantiate BANKS copies of dff_ram_bank in a generate loop.
REQ-039 dff_ram_2p SHALL own the FSM, the bank decode, the output mux, the bypass logic and the output registers.

Verification (defaults: WIDTH=72, DEPTH=8, BANKS=2)
REQ-040 Init sweep: release rst_n -> init_done rises after exactly 8 edges; reads of addr 0..7 return 0; a we pulse during INIT leaves memory 0.
REQ-041 Masked write: write 0xFF_FFFF_FFFF_FFFF_FFFF to addr 5 with wmask=0x1FF, then write 0x00 data to addr 5 with wmask=0x001 -> read addr 5 gives 0xFF_FFFF_FFFF_FFFF_FF00 with rvalid one cycle later.
REQ-042 Bank split: write 0x1 to addr 3 and 0x2 to addr 4 -> reads return 0x1 and 0x2, proving no aliasing across banks.
REQ-043 Same-address collision: addr 2 holds 0xAA; write 0xBB to addr 2 with wmask=0x1FF while reading addr 2 -> rdata=0xBB with the macro defined, 0xAA without it.
REQ-044 Streaming reads: re=1 on addr 0,1,2,3 in consecutive cycles -> rvalid stays high 4 cycles, data in order.
REQ-045 Mid-sweep reset: assert rst_n low at INIT cycle 3 -> rdata, rvalid, init_done go to 0 at once; after release, a full 8-cycle sweep occurs.
